// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel multiplexer.
// Holds the control state encoding and the mode input encoding.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SCAN_LOAD  = 2'd1,
        SCAN_DWELL = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_next_ch.sv
// Circular priority search: first enabled channel at or after start.
// Ports: en_mask (eligible channels), start (search origin), nxt (hit), any_en (hit exists).
module scan_next_ch
    import scan_mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  en_mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] nxt,
    output logic             any_en
);

    logic [SEL_W:0] idx;

    always_comb begin
        nxt    = '0;
        any_en = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, start} + (SEL_W+1)'(i);
            // start < N_CH, so a single subtract is enough to wrap
            if (idx >= (SEL_W+1)'(N_CH))
                idx = idx - (SEL_W+1)'(N_CH);
            if (!any_en && en_mask[idx[SEL_W-1:0]]) begin
                any_en = 1'b1;
                nxt    = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with manual select or round-robin scan with dwell.
// Ports: clk, reset, din (packed channels), mode, sel, en_mask, dwell,
//        y/y_ch/y_valid output sample with y_ready downstream accept.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int N_CH    = 8,
    parameter  int WIDTH   = 8,
    parameter  int DWELL_W = 4,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*WIDTH-1:0] din,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       en_mask,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [WIDTH-1:0]      y,
    output logic [SEL_W-1:0]      y_ch,
    output logic                  y_valid,
    input  logic                  y_ready
);

    state_t               state;
    logic [SEL_W-1:0]     ptr;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [WIDTH-1:0]     ch_data [N_CH];
    logic [SEL_W-1:0]     nxt;
    logic [SEL_W-1:0]     ptr_inc;
    logic                 any_en;
    logic                 load;
    logic                 sel_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_data[k] = din[k*WIDTH +: WIDTH];
    end

    scan_next_ch #(.N_CH(N_CH)) u_next (
        .en_mask (en_mask),
        .start   (ptr),
        .nxt     (nxt),
        .any_en  (any_en)
    );

    // Output slot is free when empty or being drained this cycle
    assign load    = !y_valid || y_ready;
    // Out-of-range select (non power-of-2 N_CH) never yields a sample
    assign sel_ok  = (int'(sel) < N_CH) ? en_mask[sel] : 1'b0;
    assign ptr_inc = (nxt == SEL_W'(N_CH-1)) ? '0 : nxt + SEL_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            y_ch      <= '0;
            y_valid   <= 1'b0;
            ptr       <= '0;
            dwell_cnt <= '0;
            state     <= MANUAL;
        end else if (state == SCAN_DWELL) begin
            // Dwell runs on regardless of backpressure
            if (y_valid && y_ready)
                y_valid <= 1'b0;
            if (mode == MODE_MANUAL) begin
                dwell_cnt <= '0;
                state     <= MANUAL;
            end else begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
                if (dwell_cnt == DWELL_W'(1))
                    state <= SCAN_LOAD;
            end
        end else if (load) begin
            if (mode == MODE_MANUAL) begin
                state <= MANUAL;
                if (sel_ok) begin
                    y       <= ch_data[sel];
                    y_ch    <= sel;
                    y_valid <= 1'b1;
                end else begin
                    y_valid <= 1'b0;
                end
            end else if (any_en) begin
                y       <= ch_data[nxt];
                y_ch    <= nxt;
                y_valid <= 1'b1;
                ptr     <= ptr_inc;
                if (dwell == '0) begin
                    state <= SCAN_LOAD;
                end else begin
                    dwell_cnt <= dwell;
                    state     <= SCAN_DWELL;
                end
            end else begin
                y_valid <= 1'b0;
                state   <= SCAN_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: 8-channel and 5-channel instances.
// Table of per-cycle vectors plus hand sequences for reset, dwell and wrap.
module tb_scan_mux;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // 8-channel instance
    logic [63:0] din8;
    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  mask8;
    logic [3:0]  dwell8;
    logic [7:0]  y8;
    logic [2:0]  ych8;
    logic        yv8;
    logic        rdy8;

    // 5-channel instance
    logic [39:0] din5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  mask5;
    logic [3:0]  dwell5;
    logic [7:0]  y5;
    logic [2:0]  ych5;
    logic        yv5;
    logic        rdy5;

    scan_mux #(.N_CH(8), .WIDTH(8), .DWELL_W(4)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .din     (din8),
        .mode    (mode8),
        .sel     (sel8),
        .en_mask (mask8),
        .dwell   (dwell8),
        .y       (y8),
        .y_ch    (ych8),
        .y_valid (yv8),
        .y_ready (rdy8)
    );

    scan_mux #(.N_CH(5), .WIDTH(8), .DWELL_W(4)) dut5 (
        .clk     (clk),
        .reset   (reset),
        .din     (din5),
        .mode    (mode5),
        .sel     (sel5),
        .en_mask (mask5),
        .dwell   (dwell5),
        .y       (y5),
        .y_ch    (ych5),
        .y_valid (yv5),
        .y_ready (rdy5)
    );

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] mask;
        logic       ready;
        logic       ev;
        logic [7:0] ey;
        logic [2:0] ech;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic ev,
                        input logic [7:0] ey, input logic [2:0] ech);
        check({name, ".valid"}, 32'(yv8), 32'(ev));
        check({name, ".y"}, 32'(y8), 32'(ey));
        check({name, ".ch"}, 32'(ych8), 32'(ech));
    endtask

    function automatic void add(input logic m, input logic [2:0] s,
                                input logic [7:0] mk, input logic r,
                                input logic ev, input logic [7:0] ey,
                                input logic [2:0] ech);
        vt.push_back('{m, s, mk, r, ev, ey, ech});
    endfunction

    initial begin
        int dw_seq[3];
        int exp5;

        for (int k = 0; k < 8; k++)
            din8[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 5; k++)
            din5[k*8 +: 8] = 8'h50 + 8'(k);

        reset  = 1'b1;
        mode8  = 1'b1;
        sel8   = 3'd0;
        mask8  = 8'hFF;
        dwell8 = 4'd0;
        rdy8   = 1'b1;
        mode5  = 1'b0;
        sel5   = 3'd0;
        mask5  = 5'h1F;
        dwell5 = 4'd0;
        rdy5   = 1'b1;

        // Reset state, then scan from ch0, then async reset mid-scan
        repeat (2) step();
        chk8("reset", 1'b0, 8'h00, 3'd0);
        reset = 1'b0;
        step();
        chk8("scan_first", 1'b1, 8'h10, 3'd0);
        step();
        chk8("scan_second", 1'b1, 8'h11, 3'd1);
        #3 reset = 1'b1;
        #1;
        chk8("async_reset", 1'b0, 8'h00, 3'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk8("after_reset", 1'b1, 8'h10, 3'd0);

        // Manual select sweep (ptr is now 1)
        for (int k = 0; k < 8; k++)
            add(1'b0, 3'(k), 8'hFF, 1'b1, 1'b1, 8'h10 + 8'(k), 3'(k));
        add(1'b0, 3'd3, 8'hF7, 1'b1, 1'b0, 8'h17, 3'd7);
        add(1'b0, 3'd4, 8'hF7, 1'b1, 1'b1, 8'h14, 3'd4);
        add(1'b0, 3'd5, 8'hFF, 1'b0, 1'b1, 8'h14, 3'd4);
        add(1'b0, 3'd5, 8'hFF, 1'b1, 1'b1, 8'h15, 3'd5);
        // Scan dwell 0, mask A5, resuming from ptr 1
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h12, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h15, 3'd5);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h17, 3'd7);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h10, 3'd0);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h12, 3'd2);
        // Backpressure: 5 stalled cycles, then no skip or repeat
        for (int k = 0; k < 5; k++)
            add(1'b1, 3'd0, 8'hA5, 1'b0, 1'b1, 8'h12, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h15, 3'd5);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h17, 3'd7);
        // Mode change while a sample is held must not drop it
        add(1'b1, 3'd0, 8'hA5, 1'b0, 1'b1, 8'h17, 3'd7);
        add(1'b0, 3'd1, 8'hFF, 1'b0, 1'b1, 8'h17, 3'd7);
        add(1'b0, 3'd1, 8'hFF, 1'b1, 1'b1, 8'h11, 3'd1);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h10, 3'd0);
        // Empty mask in scan: no samples, ptr kept
        add(1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 8'h10, 3'd0);
        add(1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 8'h10, 3'd0);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 8'h12, 3'd2);

        foreach (vt[i]) begin
            mode8 = vt[i].mode;
            sel8  = vt[i].sel;
            mask8 = vt[i].mask;
            rdy8  = vt[i].ready;
            step();
            chk8($sformatf("vec%0d", i), vt[i].ev, vt[i].ey, vt[i].ech);
        end

        // Dwell 3: one sample every 4 cycles
        mode8  = 1'b1;
        mask8  = 8'hA5;
        rdy8   = 1'b1;
        dwell8 = 4'd3;
        dw_seq = '{5, 7, 0};
        foreach (dw_seq[i]) begin
            step();
            chk8($sformatf("dwell_s%0d", i), 1'b1, 8'h10 + 8'(dw_seq[i]),
                 3'(dw_seq[i]));
            for (int c = 1; c < 4; c++) begin
                step();
                check($sformatf("dwell_gap%0d_%0d", i, c), 32'(yv8), 32'd0);
            end
        end
        step();
        chk8("dwell_next", 1'b1, 8'h12, 3'd2);
        // Leaving scan during dwell drops straight to manual
        mode8 = 1'b0;
        sel8  = 3'd5;
        step();
        check("dwell_exit.valid", 32'(yv8), 32'd0);
        step();
        chk8("dwell_exit_manual", 1'b1, 8'h15, 3'd5);
        dwell8 = 4'd0;

        // N_CH=5: out-of-range select, then scan wrap 4->0
        mode5 = 1'b0;
        sel5  = 3'd6;
        step();
        check("n5_sel6.valid", 32'(yv5), 32'd0);
        sel5 = 3'd4;
        step();
        check("n5_sel4.valid", 32'(yv5), 32'd1);
        check("n5_sel4.y", 32'(y5), 32'h54);
        sel5 = 3'd7;
        step();
        check("n5_sel7.valid", 32'(yv5), 32'd0);
        mode5 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp5 = k % 5;
            step();
            check($sformatf("n5_scan%0d.valid", k), 32'(yv5), 32'd1);
            check($sformatf("n5_scan%0d.ch", k), 32'(ych5), 32'(exp5));
            check($sformatf("n5_scan%0d.y", k), 32'(y5), 32'h50 + 32'(exp5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel multiplexer; successor to the fixed 8-input 1-bit combinational mux.
- Two modes: manual, where an external select picks the channel, and scan, where the block steps round-robin through enabled channels with a programmable dwell.
- Output is a registered word plus channel tag, using a valid/ready handshake toward downstream logic (sampler, serialiser, debug capture).

Parameters:
N_CH, 8, number of input channels (>=2, need not be a power of 2)
WIDTH, 8, bits per channel
DWELL_W, 4, width of the dwell-count input
SEL_W, $clog2(N_CH), derived (localparam), width of channel index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
din  input  N_CH*WIDTH  packed channel data; channel k = din[k*WIDTH +: WIDTH]
mode  input  1  0 = manual, 1 = scan
sel  input  SEL_W  manual-mode channel select
en_mask  input  N_CH  per-channel enable; bit k=1 means channel k is eligible
dwell  input  DWELL_W  scan mode: extra idle cycles after each accepted sample before advancing
y  output  WIDTH  registered selected data
y_ch  output  SEL_W  channel index that y came from
y_valid  output  1  y/y_ch hold a sample not yet accepted
y_ready  input  1  downstream accepts when y_valid && y_ready

Behaviour:
- Reset (async, takes effect immediately, also mid-scan): y=0, y_ch=0, y_valid=0, ptr=0, dwell_cnt=0, state=MANUAL.
- Slot free ("load") condition: !y_valid || y_ready. While y_valid && !y_ready, y and y_ch stay stable. There is no combinational path from y_ready to y, y_ch or y_valid.
- States: MANUAL, SCAN_LOAD, SCAN_DWELL. The state is MANUAL when mode=0. On a load cycle, mode is sampled and the state moves to MANUAL or SCAN_LOAD accordingly; a mode change never discards a held sample.
- MANUAL, on a load cycle:
  - Capture y <= din[sel] and y_ch <= sel.
  - y_valid <= 1 when sel < N_CH and en_mask[sel]=1; otherwise y_valid <= 0 and y/y_ch hold.
  - Latency is 1 cycle from sel/din to y.
- SCAN_LOAD, on a load cycle:
  - Find nxt, the first enabled channel searching circularly from ptr inclusive.
  - Capture y <= din[nxt], y_ch <= nxt, y_valid <= 1, ptr <= nxt+1 with wrap at N_CH (not at 2^SEL_W).
  - If dwell==0, stay in SCAN_LOAD. Otherwise load dwell_cnt <= dwell and go to SCAN_DWELL.
  - If en_mask==0: y_valid <= 0, ptr unchanged, stay in SCAN_LOAD.
- SCAN_DWELL: dwell_cnt decrements every cycle regardless of y_ready. At dwell_cnt==1, go to SCAN_LOAD. mode=0 during dwell moves to MANUAL on the next cycle.
- Throughput: dwell=0 with y_ready held at 1 gives one sample per cycle. Channel spacing is then dwell+1 cycles, plus any backpressure stall.
- en_mask is sampled at search time. Disabling the channel currently held in y does not drop it.
- Entering scan from manual resumes from the retained ptr.
- When sel is out of range (N_CH not a power of 2), no sample is produced.

Decomposition:
- Package scan_mux_pkg holds:
  - typedef enum logic [1:0] {MANUAL, SCAN_LOAD, SCAN_DWELL} state_t
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1
- One sub-module, scan_next_ch (combinational, parameter N_CH):
  - Inputs: en_mask, start index.
  - Outputs: nxt index and any_en flag (circular priority search).
- Everything else lives in scan_mux.

Test Plan:
1. Reset: assert reset mid-scan with y_valid=1 -> same cycle y=0, y_ch=0, y_valid=0; after release with mode=1, en_mask=8'hFF, first sample is ch0.
2. Manual with N_CH=8, WIDTH=8, din[k]=8'h10+k, en_mask=8'hFF, y_ready=1, sel stepping 0..7 -> one cycle later y=8'h10..8'h17 and y_ch=0..7; with en_mask[3]=0, sel=3 -> y_valid=0.
3. Scan with dwell=0, y_ready=1, en_mask=8'b1010_0101 -> y_ch sequence 0,2,5,7,0,2,... one per cycle, y=din[y_ch].
4. Scan with dwell=3 -> each new y_ch appears exactly 4 cycles after the previous one; y_valid high on 1 cycle of 4.
5. Backpressure: y_ready=0 for 5 cycles while y_valid=1 -> y and y_ch stable; on release the next channel follows, with no channel skipped or duplicated.
6. Corner cases:
   - en_mask=0 in scan -> y_valid stays 0.
   - N_CH=5 manual with sel=6 -> y_valid=0.
   - N_CH=5 scan, all channels enabled -> ptr wraps 4->0.
